bip_control: RTL and testbench

Multi-cycle control unit for the BIP accumulator processor. It fetches 16-bit instructions from program memory, decodes them, and sequences the shared 16-bit signed add/sub ALU, the accumulator and data memory. It sits between the program/data memories and the ALU, which stays purely combinational: one-bit opcode, 1 = add, 0 = subtract.

---
 rtl/bip_control.sv | 196 +++++++++++++++++++
 tb/tb_bip_control.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// bip_control: multi-cycle fetch/decode/execute sequencer for the BIP
// accumulator processor. It drives the program memory, the data memory and an
// external combinational add/sub ALU.
// Optional feature: define BIP_CTRL_OVF_EN to build the sticky signed-overflow flag.
// Without that macro, ovf_o is tied to 0.
module bip_control #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] prog_addr_o,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic [ADDR_W-1:0] data_addr_o,
  input  logic [DATA_W-1:0] data_rd_i,
  output logic [DATA_W-1:0] data_wr_o,
  output logic              data_we_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic              alu_op_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic [DATA_W-1:0] acc_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic              ovf_o
);

  localparam int unsigned OPC_W = DATA_W - ADDR_W;
  localparam int unsigned EXT_W = DATA_W - ADDR_W;

  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] ir_q;
  logic [ADDR_W-1:0] daddr_q;

  logic [OPC_W-1:0]  opcode;
  logic [OPC_W-1:0]  dec_opcode;
  logic [DATA_W-1:0] sext_operand;
  logic [DATA_W-1:0] alu_b;
  logic              alu_op;

  assign opcode       = ir_q[DATA_W-1:ADDR_W];
  assign dec_opcode   = prog_data_i[DATA_W-1:ADDR_W];
  assign sext_operand = {{EXT_W{ir_q[ADDR_W-1]}}, ir_q[ADDR_W-1:0]};

  // ALU operand B and opcode: immediates in EXEC, memory operands in MEM
  always_comb begin
    alu_b  = '0;
    alu_op = 1'b1;
    if (state_q == S_EXEC) begin
      if (opcode == OP_ADDI) begin
        alu_b  = sext_operand;
        alu_op = 1'b1;
      end else if (opcode == OP_SUBI) begin
        alu_b  = sext_operand;
        alu_op = 1'b0;
      end
    end else if (state_q == S_MEM) begin
      if (opcode == OP_ADD) begin
        alu_b  = data_rd_i;
        alu_op = 1'b1;
      end else if (opcode == OP_SUB) begin
        alu_b  = data_rd_i;
        alu_op = 1'b0;
      end
    end
  end

  // Control FSM with PC, IR, ACC and data address registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      ir_q    <= '0;
      daddr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start_i) begin
            pc_q    <= '0;
            acc_q   <= '0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          ir_q    <= prog_data_i;
          pc_q    <= pc_q + ADDR_W'(1);
          // Only memory-touching instructions move the data address
          if ((dec_opcode == OP_STO) || (dec_opcode == OP_LD) ||
              (dec_opcode == OP_ADD) || (dec_opcode == OP_SUB)) begin
            daddr_q <= prog_data_i[ADDR_W-1:0];
          end
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          case (opcode)
            OP_HLT:           state_q <= S_HALT;
            OP_LDI: begin
              acc_q   <= sext_operand;
              state_q <= S_FETCH;
            end
            OP_ADDI, OP_SUBI: begin
              acc_q   <= alu_result_i;
              state_q <= S_FETCH;
            end
            OP_LD, OP_ADD, OP_SUB: state_q <= S_MEM;
            default:          state_q <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (opcode == OP_LD) begin
            acc_q <= data_rd_i;
          end else begin
            acc_q <= alu_result_i;
          end
          state_q <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef BIP_CTRL_OVF_EN
  logic ovf_q;
  logic ovf_hit;
  logic alu_cyc;

  // Signed overflow detection on every accumulator-updating ALU cycle
  always_comb begin
    alu_cyc = ((state_q == S_EXEC) && ((opcode == OP_ADDI) || (opcode == OP_SUBI))) ||
              ((state_q == S_MEM)  && ((opcode == OP_ADD)  || (opcode == OP_SUB)));
    ovf_hit = 1'b0;
    if (alu_cyc) begin
      if (alu_op) begin
        ovf_hit = (acc_q[DATA_W-1] == alu_b[DATA_W-1]) &&
                  (alu_result_i[DATA_W-1] != acc_q[DATA_W-1]);
      end else begin
        ovf_hit = (acc_q[DATA_W-1] != alu_b[DATA_W-1]) &&
                  (alu_result_i[DATA_W-1] != acc_q[DATA_W-1]);
      end
    end
  end

  // Sticky overflow flag, cleared by reset or an accepted start
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (((state_q == S_IDLE) || (state_q == S_HALT)) && start_i) begin
      ovf_q <= 1'b0;
    end else if (ovf_hit) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign prog_addr_o = pc_q;
  assign data_addr_o = daddr_q;
  assign data_wr_o   = acc_q;
  assign data_we_o   = (state_q == S_EXEC) && (opcode == OP_STO);
  assign alu_a_o     = acc_q;
  assign alu_b_o     = alu_b;
  assign alu_op_o    = alu_op;
  assign acc_o       = acc_q;
  assign busy_o      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_EXEC)  || (state_q == S_MEM);
  assign halted_o    = (state_q == S_HALT);

endmodule

// File: tb/tb_bip_control.sv
// Testbench for bip_control: an instruction-level reference model predicts
// architectural state, write strobes and ALU operations into queues, which a
// negedge monitor pops and compares against the DUT.
module tb_bip_control;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

`ifdef BIP_CTRL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  localparam logic [4:0] OP_HLT  = 5'd0;
  localparam logic [4:0] OP_STO  = 5'd1;
  localparam logic [4:0] OP_LD   = 5'd2;
  localparam logic [4:0] OP_LDI  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_SUBI = 5'd7;
  localparam logic [4:0] OP_NOP  = 5'd31;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data = '0;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_rd = '0;
  logic [DW-1:0] data_wr;
  logic          data_we;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          alu_op;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] acc;
  logic          busy;
  logic          halted;
  logic          ovf;

  bip_control #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .prog_addr_o(prog_addr), .prog_data_i(prog_data),
    .data_addr_o(data_addr), .data_rd_i(data_rd),
    .data_wr_o(data_wr), .data_we_o(data_we),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_result_i(alu_result), .acc_o(acc),
    .busy_o(busy), .halted_o(halted), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  // Combinational ALU and synchronous-read memories around the DUT
  assign alu_result = alu_op ? (alu_a + alu_b) : (alu_a - alu_b);

  logic [DW-1:0] pmem [2048];
  logic [DW-1:0] dmem [2048];

  always @(posedge clk) begin
    prog_data <= pmem[prog_addr];
    data_rd   <= dmem[data_addr];
    if (data_we) dmem[data_addr] <= data_wr;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int cyc; logic [DW-1:0] acc; logic [AW-1:0] pc; logic ov; } bnd_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int cyc; logic op; logic [DW-1:0] b; } alu_t;

  bnd_t bnd_q[$];
  wr_t  wr_q[$];
  alu_t alu_q[$];
  int   halt_cyc = -10;
  bit   mon_en = 1'b0;

  function automatic logic [DW-1:0] ins(input logic [4:0] op, input logic [AW-1:0] arg);
    return {op, arg};
  endfunction

  function automatic logic add_ov(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [DW-1:0] r);
    return (a[15] == b[15]) && (r[15] != a[15]);
  endfunction

  function automatic logic sub_ov(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [DW-1:0] r);
    return (a[15] != b[15]) && (r[15] != a[15]);
  endfunction

  // Instruction-level model: pushes expectations, FETCH of the first instruction at t0
  task automatic model_run(input int t0, input bit patch);
    logic [AW-1:0] pc;
    logic [DW-1:0] a, ir, sx, b, r;
    logic          ov;
    logic [AW-1:0] opnd;
    int            t, lat;
    logic [DW-1:0] pm [2048];
    logic [DW-1:0] dm [2048];
    pm = pmem;
    dm = dmem;
    pc = '0; a = '0; ov = 1'b0; t = t0;
    bnd_q.push_back(bnd_t'{t0, a, pc, ov});
    for (int n = 0; n < 4000; n++) begin
      ir   = pm[pc];
      pc   = pc + 11'd1;
      if (patch && n == 0) pm[0] = ins(OP_HLT, 11'd0);
      opnd = ir[10:0];
      sx   = {{5{ir[10]}}, ir[10:0]};
      lat  = 3;
      case (ir[15:11])
        OP_HLT: begin
          halt_cyc = t + 3;
          bnd_q.push_back(bnd_t'{t + 3, a, pc, ov});
          return;
        end
        OP_LDI: a = sx;
        OP_ADDI: begin
          r = a + sx; ov = ov | (OVF_EN & add_ov(a, sx, r));
          alu_q.push_back(alu_t'{t + 2, 1'b1, sx}); a = r;
        end
        OP_SUBI: begin
          r = a - sx; ov = ov | (OVF_EN & sub_ov(a, sx, r));
          alu_q.push_back(alu_t'{t + 2, 1'b0, sx}); a = r;
        end
        OP_STO: begin
          wr_q.push_back(wr_t'{t + 2, opnd, a}); dm[opnd] = a;
        end
        OP_LD: begin a = dm[opnd]; lat = 4; end
        OP_ADD: begin
          b = dm[opnd]; r = a + b; ov = ov | (OVF_EN & add_ov(a, b, r));
          alu_q.push_back(alu_t'{t + 3, 1'b1, b}); a = r; lat = 4;
        end
        OP_SUB: begin
          b = dm[opnd]; r = a - b; ov = ov | (OVF_EN & sub_ov(a, b, r));
          alu_q.push_back(alu_t'{t + 3, 1'b0, b}); a = r; lat = 4;
        end
        default: lat = 3;
      endcase
      t += lat;
      bnd_q.push_back(bnd_t'{t, a, pc, ov});
    end
    halt_cyc = t;
  endtask

  // Monitor: pop and compare expectations as the DUT produces them
  always @(negedge clk) begin
    bnd_t b;
    wr_t  w;
    alu_t a;
    if (mon_en) begin
      if (bnd_q.size() > 0 && bnd_q[0].cyc == cyc) begin
        b = bnd_q.pop_front();
        chk("bnd_acc", acc, b.acc);
        chk("bnd_pc", prog_addr, b.pc);
        chk("bnd_ovf", ovf, b.ov);
      end
      if (data_we) begin
        if (wr_q.size() == 0) begin
          chk("wr_spurious", data_we, 1'b0);
        end else begin
          w = wr_q.pop_front();
          chk("wr_cyc", cyc, w.cyc);
          chk("wr_addr", data_addr, w.addr);
          chk("wr_data", data_wr, w.data);
        end
      end
      if (alu_q.size() > 0 && alu_q[0].cyc == cyc) begin
        a = alu_q.pop_front();
        chk("alu_op", alu_op, a.op);
        chk("alu_b", alu_b, a.b);
      end
      if (cyc == halt_cyc - 1) chk("halt_early", halted, 1'b0);
      if (cyc == halt_cyc)     chk("halt", halted, 1'b1);
    end
  end

  // Start a program, optionally patch pmem[0] to HLT and pulse start mid-run
  task automatic run_prog(input bit patch, input int pulse_off);
    int t0;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    model_run(t0, patch);
    @(negedge clk);
    start = 1'b0;
    chk("fetch_busy", busy, 1'b1);
    while (cyc < halt_cyc + 2) begin
      @(negedge clk);
      start = (pulse_off > 0 && cyc == t0 + pulse_off);
      if (patch && cyc == t0 + 1) pmem[0] = ins(OP_HLT, 11'd0);
    end
    start = 1'b0;
    chk("bnd_left", bnd_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("alu_left", alu_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_acc"}, acc, 16'h0);
    chk({tag, "_pc"}, prog_addr, 11'h0);
    chk({tag, "_daddr"}, data_addr, 11'h0);
    chk({tag, "_wdata"}, data_wr, 16'h0);
    chk({tag, "_we"}, data_we, 1'b0);
    chk({tag, "_alub"}, alu_b, 16'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_halted"}, halted, 1'b0);
    chk({tag, "_ovf"}, ovf, 1'b0);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 2048; i++) begin
      pmem[i] = ins(OP_NOP, 11'd0);
      dmem[i] = '0;
    end
  endtask

  initial begin
    fill_nop();
    // Reset and idle
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("idle");

    // Immediate program
    mon_en = 1'b1;
    pmem[0] = ins(OP_LDI, 11'd5);
    pmem[1] = ins(OP_ADDI, 11'h7FD);
    pmem[2] = ins(OP_STO, 11'h010);
    pmem[3] = ins(OP_HLT, 11'd0);
    run_prog(1'b0, 0);
    chk("imm_acc", acc, 16'd2);
    chk("imm_mem", dmem[16], 16'd2);

    // Memory operands
    fill_nop();
    dmem[1] = 16'd100;
    dmem[2] = 16'd30;
    pmem[0] = ins(OP_LD, 11'd1);
    pmem[1] = ins(OP_SUB, 11'd2);
    pmem[2] = ins(OP_ADD, 11'd1);
    pmem[3] = ins(OP_HLT, 11'd0);
    run_prog(1'b0, 0);
    chk("mem_acc", acc, 16'd170);

    // Overflow, then a restart that must clear it
    fill_nop();
    dmem[5] = 16'h7FFF;
    pmem[0] = ins(OP_LDI, 11'h3FF);
    pmem[1] = ins(OP_ADD, 11'd5);
    pmem[2] = ins(OP_ADDI, 11'd1);
    pmem[3] = ins(OP_HLT, 11'd0);
    run_prog(1'b0, 0);
    chk("ovf_acc", acc, 16'h83FF);
    chk("ovf_flag", ovf, OVF_EN);
    run_prog(1'b0, 0);

    // PC wrap through 2048 NOPs with a stray start pulse mid-run
    fill_nop();
    run_prog(1'b1, 1000);
    chk("wrap_pc", prog_addr, 11'd1);

    // Reset during the EXEC cycle of STO
    mon_en = 1'b0;
    bnd_q.delete(); wr_q.delete(); alu_q.delete();
    fill_nop();
    dmem[32] = 16'hBEEF;
    pmem[0] = ins(OP_LDI, 11'd7);
    pmem[1] = ins(OP_STO, 11'h020);
    pmem[2] = ins(OP_HLT, 11'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("sto_we", data_we, 1'b1);
    chk("sto_addr", data_addr, 11'h020);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_mem", dmem[32], 16'hBEEF);
    repeat (2) @(negedge clk);
    check_reset_outputs("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
